trap_ctrl: RTL and testbench

- Trap sequencer feeding the CSR unit's trap channel (trap_csr_*) and consuming its masked interrupt outputs, mstatus MIE and mepc.
- On an interrupt, ECALL/EBREAK or MRET, it stalls the core, performs the machine-mode CSR update sequence one CSR per cycle, then issues a one-cycle jump to the handler or return address.

---
 rtl/trap_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Accepts ECALL / EBREAK / MRET and masked interrupts at an instruction
// boundary, stalls the core, writes mepc/mcause/mtval/mstatus one CSR per
// cycle through the CSR unit's trap channel, then pulses jump_o to the
// handler (mtvec) or the return address (mepc).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex/tcmp/soft_trap_i           masked interrupt pending levels
//   mstatus_MIE3_i, mepc_i        current MIE and mepc from the CSR unit
//   hx_valid, ecall/ebreak/mret_i retiring instruction and its trap kind
//   inst_pc_i, next_pc_i          PC of the instruction / next fetch PC
//   trap_csr_we/addr/wdata_o      CSR write channel
//   trap_csr_rdata_i              CSR read data (combinational from addr)
//   p*_trap_rsp                   interrupt acknowledge pulses
//   hold_o, jump_o, jump_pc_o     core stall and PC redirect
//
// Optional feature macro: TRAP_VECTOR_EN enables vectored interrupt entry
// when mtvec[1:0] == 2'b01.
//
// state     | meaning
// IDLE      | waiting for an accept at an instruction boundary
// W_MEPC    | write mepc with the captured epc
// W_MCAUSE  | write mcause with the captured cause
// W_MTVAL   | write mtval (faulting PC for ebreak, else 0)
// W_MSTATUS | MPIE <- MIE, MIE <- 0
// JMP       | read mtvec, redirect to the handler
// R_STATUS  | MIE <- MPIE, MPIE <- 1
// RJMP      | redirect to mepc
module trap_ctrl #(
  parameter int TVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_trap_i,
  input  logic        tcmp_trap_i,
  input  logic        soft_trap_i,
  input  logic        mstatus_MIE3_i,
  input  logic [31:0] mepc_i,
  input  logic        hx_valid,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic [31:0] inst_pc_i,
  input  logic [31:0] next_pc_i,
  output logic        trap_csr_we_o,
  output logic [11:0] trap_csr_addr_o,
  output logic [31:0] trap_csr_wdata_o,
  input  logic [31:0] trap_csr_rdata_i,
  output logic        pex_trap_rsp,
  output logic        ptcmp_trap_rsp,
  output logic        psoft_trap_rsp,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_pc_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, JMP, R_STATUS, RJMP
  } state_t;

  localparam logic [31:0] TVEC_MASK = ~((32'd1 << TVEC_ALIGN) - 32'd1);

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic        accept;
  logic        irq_ok;

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    tval_d           = tval_q;
    accept           = 1'b0;
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = 12'h000;
    trap_csr_wdata_o = 32'h0;
    pex_trap_rsp     = 1'b0;
    ptcmp_trap_rsp   = 1'b0;
    psoft_trap_rsp   = 1'b0;
    jump_o           = 1'b0;
    jump_pc_o        = 32'h0;
    irq_ok           = hx_valid & mstatus_MIE3_i;

    // Outputs are forced to zero while rst is high so that no partial CSR
    // write or redirect escapes during a reset issued mid-sequence.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (hx_valid & ecall_i) begin
            accept  = 1'b1;
            cause_d = 32'd11;
            epc_d   = inst_pc_i;
            tval_d  = 32'h0;
            state_d = W_MEPC;
          end else if (hx_valid & ebreak_i) begin
            accept  = 1'b1;
            cause_d = 32'd3;
            epc_d   = inst_pc_i;
            tval_d  = inst_pc_i;
            state_d = W_MEPC;
          end else if (hx_valid & mret_i) begin
            accept  = 1'b1;
            state_d = R_STATUS;
          end else if (irq_ok & ex_trap_i) begin
            accept       = 1'b1;
            pex_trap_rsp = 1'b1;
            cause_d      = 32'h8000_000B;
            epc_d        = next_pc_i;
            tval_d       = 32'h0;
            state_d      = W_MEPC;
          end else if (irq_ok & soft_trap_i) begin
            accept         = 1'b1;
            psoft_trap_rsp = 1'b1;
            cause_d        = 32'h8000_0003;
            epc_d          = next_pc_i;
            tval_d         = 32'h0;
            state_d        = W_MEPC;
          end else if (irq_ok & tcmp_trap_i) begin
            accept         = 1'b1;
            ptcmp_trap_rsp = 1'b1;
            cause_d        = 32'h8000_0007;
            epc_d          = next_pc_i;
            tval_d         = 32'h0;
            state_d        = W_MEPC;
          end
        end
        W_MEPC: begin
          trap_csr_we_o    = 1'b1;
          trap_csr_addr_o  = 12'h341;
          trap_csr_wdata_o = epc_q;
          state_d          = W_MCAUSE;
        end
        W_MCAUSE: begin
          trap_csr_we_o    = 1'b1;
          trap_csr_addr_o  = 12'h342;
          trap_csr_wdata_o = cause_q;
          state_d          = W_MTVAL;
        end
        W_MTVAL: begin
          trap_csr_we_o    = 1'b1;
          trap_csr_addr_o  = 12'h343;
          trap_csr_wdata_o = tval_q;
          state_d          = W_MSTATUS;
        end
        W_MSTATUS: begin
          trap_csr_we_o    = 1'b1;
          trap_csr_addr_o  = 12'h300;
          trap_csr_wdata_o = trap_csr_rdata_i;
          trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
          trap_csr_wdata_o[3] = 1'b0;
          state_d          = JMP;
        end
        JMP: begin
          // Address is driven without a write so the CSR unit returns mtvec.
          trap_csr_addr_o = 12'h305;
          jump_o          = 1'b1;
`ifdef TRAP_VECTOR_EN
          if (trap_csr_rdata_i[1:0] == 2'b01 && cause_q[31])
            jump_pc_o = {trap_csr_rdata_i[31:2], 2'b00} + {cause_q[29:0], 2'b00};
          else if (trap_csr_rdata_i[1:0] == 2'b01)
            jump_pc_o = {trap_csr_rdata_i[31:2], 2'b00};
          else
            jump_pc_o = trap_csr_rdata_i & TVEC_MASK;
`else
          jump_pc_o = trap_csr_rdata_i & TVEC_MASK;
`endif
          state_d = IDLE;
        end
        R_STATUS: begin
          trap_csr_we_o    = 1'b1;
          trap_csr_addr_o  = 12'h300;
          trap_csr_wdata_o = trap_csr_rdata_i;
          trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
          trap_csr_wdata_o[7] = 1'b1;
          state_d          = RJMP;
        end
        RJMP: begin
          jump_o    = 1'b1;
          jump_pc_o = mepc_i;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    hold_o = !rst && ((state_q != IDLE) || accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= 32'h0;
      epc_q   <= 32'h0;
      tval_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl. A tiny CSR model answers
// reads of mstatus (0x300) and mtvec (0x305) from bench-held values.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_trap_i, tcmp_trap_i, soft_trap_i, mstatus_MIE3_i;
  logic [31:0] mepc_i;
  logic        hx_valid, ecall_i, ebreak_i, mret_i;
  logic [31:0] inst_pc_i, next_pc_i;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o, trap_csr_rdata_i;
  logic        pex_trap_rsp, ptcmp_trap_rsp, psoft_trap_rsp;
  logic        hold_o, jump_o;
  logic [31:0] jump_pc_o;

  logic [31:0] mstatus_v, mtvec_v;

  int n_tests = 0;
  int n_fail  = 0;

  // per-cycle trace of one sequence, index 0 = accept cycle
  logic        tr_we  [8];
  logic [11:0] tr_addr[8];
  logic [31:0] tr_wd  [8];
  logic        tr_j   [8];
  logic [31:0] tr_jpc [8];
  logic        tr_h   [8];
  logic [2:0]  tr_rsp [8];  // {ex, soft, timer}

  always #5 clk = ~clk;

  always_comb begin
    trap_csr_rdata_i = 32'h0;
    if (trap_csr_addr_o == 12'h300)      trap_csr_rdata_i = mstatus_v;
    else if (trap_csr_addr_o == 12'h305) trap_csr_rdata_i = mtvec_v;
  end

  trap_ctrl #(.TVEC_ALIGN(2)) dut (
    .clk(clk), .rst(rst),
    .ex_trap_i(ex_trap_i), .tcmp_trap_i(tcmp_trap_i), .soft_trap_i(soft_trap_i),
    .mstatus_MIE3_i(mstatus_MIE3_i), .mepc_i(mepc_i),
    .hx_valid(hx_valid), .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .inst_pc_i(inst_pc_i), .next_pc_i(next_pc_i),
    .trap_csr_we_o(trap_csr_we_o), .trap_csr_addr_o(trap_csr_addr_o),
    .trap_csr_wdata_o(trap_csr_wdata_o), .trap_csr_rdata_i(trap_csr_rdata_i),
    .pex_trap_rsp(pex_trap_rsp), .ptcmp_trap_rsp(ptcmp_trap_rsp),
    .psoft_trap_rsp(psoft_trap_rsp),
    .hold_o(hold_o), .jump_o(jump_o), .jump_pc_o(jump_pc_o)
  );

  // Drives one instruction-boundary request (called just after a posedge)
  // and records ncyc cycles of outputs into the trace arrays.
  task automatic issue(input logic ec, eb, mr, ex, so, tm, mie,
                       input logic [31:0] ipc, npc, input int ncyc);
    ecall_i = ec; ebreak_i = eb; mret_i = mr;
    ex_trap_i = ex; soft_trap_i = so; tcmp_trap_i = tm;
    mstatus_MIE3_i = mie; inst_pc_i = ipc; next_pc_i = npc;
    hx_valid = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      #1;
      tr_we[k] = trap_csr_we_o;  tr_addr[k] = trap_csr_addr_o;
      tr_wd[k] = trap_csr_wdata_o; tr_j[k] = jump_o; tr_jpc[k] = jump_pc_o;
      tr_h[k] = hold_o;
      tr_rsp[k] = {pex_trap_rsp, psoft_trap_rsp, ptcmp_trap_rsp};
      @(posedge clk); #1;
      hx_valid = 1'b0; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hx_valid = 1'b1; ecall_i = 1'b1;
    ebreak_i = 0; mret_i = 0; ex_trap_i = 0; soft_trap_i = 0; tcmp_trap_i = 0;
    mstatus_MIE3_i = 0; mepc_i = 0; inst_pc_i = 32'h40; next_pc_i = 32'h44;
    mstatus_v = 32'h0; mtvec_v = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({trap_csr_we_o, hold_o, jump_o, pex_trap_rsp, psoft_trap_rsp, ptcmp_trap_rsp} !== 6'b0 ||
        trap_csr_addr_o !== 12'h0 || trap_csr_wdata_o !== 32'h0 || jump_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs we=%b hold=%b jump=%b addr=%h wd=%h jpc=%h, want all 0",
               trap_csr_we_o, hold_o, jump_o, trap_csr_addr_o, trap_csr_wdata_o, jump_pc_o);
    end
    rst = 1'b0; hx_valid = 1'b0; ecall_i = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (hold_o !== 1'b0 || trap_csr_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle hold=%b we=%b, want 0 0", hold_o, trap_csr_we_o);
    end
  endtask

  task automatic test_ext_irq();
    logic [11:0] ea[1:4];
    logic [31:0] ew[1:4];
    int npulse;
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ew = '{32'h2004, 32'h8000_000B, 32'h0, 32'h80};
    mstatus_v = 32'h8; mtvec_v = 32'h100;
    issue(0, 0, 0, 1, 0, 0, 1, 32'h2000, 32'h2004, 7);
    npulse = 0;
    for (int k = 0; k < 7; k++) npulse += int'(tr_rsp[k][2]);
    n_tests++;
    if (tr_rsp[0] !== 3'b100 || npulse != 1) begin
      n_fail++;
      $display("FAIL ext_rsp rsp0=%b pulses=%0d, want 100 and 1", tr_rsp[0], npulse);
    end
    n_tests++;
    if (tr_h[0] !== 1'b1 || tr_we[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_accept hold=%b we=%b, want 1 0", tr_h[0], tr_we[0]);
    end
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (tr_we[k] !== 1'b1 || tr_addr[k] !== ea[k] || tr_wd[k] !== ew[k] || tr_j[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL ext_write%0d we=%b addr=%h wd=%h j=%b, want 1 %h %h 0",
                 k, tr_we[k], tr_addr[k], tr_wd[k], tr_j[k], ea[k], ew[k]);
      end
    end
    n_tests++;
    if (tr_j[5] !== 1'b1 || tr_jpc[5] !== 32'h100 || tr_h[5] !== 1'b1 ||
        tr_we[5] !== 1'b0 || tr_addr[5] !== 12'h305) begin
      n_fail++;
      $display("FAIL ext_jump j=%b pc=%h hold=%b we=%b addr=%h, want 1 00000100 1 0 305",
               tr_j[5], tr_jpc[5], tr_h[5], tr_we[5], tr_addr[5]);
    end
    n_tests++;
    if (tr_h[6] !== 1'b0 || tr_j[6] !== 1'b0 || tr_we[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_after hold=%b j=%b we=%b, want 0 0 0", tr_h[6], tr_j[6], tr_we[6]);
    end
  endtask

  task automatic test_ecall_no_mie();
    mstatus_v = 32'h0; mtvec_v = 32'h100;
    issue(1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h3004, 7);
    n_tests++;
    if (tr_wd[1] !== 32'h3000 || tr_wd[2] !== 32'd11 || tr_wd[3] !== 32'h0 || tr_wd[4] !== 32'h0) begin
      n_fail++;
      $display("FAIL ecall_writes mepc=%h mcause=%h mtval=%h mstatus=%h, want 3000 b 0 0",
               tr_wd[1], tr_wd[2], tr_wd[3], tr_wd[4]);
    end
    n_tests++;
    if (tr_j[5] !== 1'b1 || tr_jpc[5] !== 32'h100 || tr_j[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL ecall_jump j4=%b j5=%b pc=%h, want 0 1 00000100", tr_j[4], tr_j[5], tr_jpc[5]);
    end
    n_tests++;
    if ((tr_rsp[0] | tr_rsp[1] | tr_rsp[5]) !== 3'b000) begin
      n_fail++;
      $display("FAIL ecall_rsp rsp=%b, want 000", tr_rsp[0] | tr_rsp[1] | tr_rsp[5]);
    end
  endtask

  task automatic test_ebreak();
    // mtvec low bits set: they must be cleared in the handler address
    mstatus_v = 32'h8; mtvec_v = 32'h0000_0203;
    issue(0, 1, 0, 0, 0, 0, 1, 32'h5550, 32'h5554, 6);
    n_tests++;
    if (tr_wd[1] !== 32'h5550 || tr_wd[2] !== 32'd3 || tr_wd[3] !== 32'h5550 || tr_wd[4] !== 32'h80) begin
      n_fail++;
      $display("FAIL ebreak_writes mepc=%h mcause=%h mtval=%h mstatus=%h, want 5550 3 5550 80",
               tr_wd[1], tr_wd[2], tr_wd[3], tr_wd[4]);
    end
    n_tests++;
    if (tr_j[5] !== 1'b1 || tr_jpc[5] !== 32'h200) begin
      n_fail++;
      $display("FAIL ebreak_jump j=%b pc=%h, want 1 00000200", tr_j[5], tr_jpc[5]);
    end
  endtask

  task automatic test_ecall_beats_irq();
    mstatus_v = 32'h8; mtvec_v = 32'h100;
    issue(1, 0, 0, 1, 1, 1, 1, 32'h6000, 32'h6004, 6);
    n_tests++;
    if (tr_rsp[0] !== 3'b000 || tr_wd[2] !== 32'd11 || tr_wd[1] !== 32'h6000) begin
      n_fail++;
      $display("FAIL ecall_prio rsp=%b mcause=%h mepc=%h, want 000 b 6000",
               tr_rsp[0], tr_wd[2], tr_wd[1]);
    end
  endtask

  task automatic test_no_accept();
    mstatus_v = 32'h0;
    issue(0, 0, 0, 1, 1, 1, 0, 32'h10, 32'h14, 3);
    n_tests++;
    if (tr_h[0] !== 1'b0 || tr_rsp[0] !== 3'b000 || tr_we[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked hold=%b rsp=%b we=%b, want 0 000 0", tr_h[0], tr_rsp[0], tr_we[1]);
    end
    ex_trap_i = 1'b1; mstatus_MIE3_i = 1'b1; hx_valid = 1'b0; #1;
    n_tests++;
    if (hold_o !== 1'b0 || pex_trap_rsp !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_no_boundary hold=%b rsp=%b, want 0 0", hold_o, pex_trap_rsp);
    end
    @(posedge clk); #1;
    ex_trap_i = 1'b0;
  endtask

  task automatic test_mret();
    mstatus_v = 32'h80; mepc_i = 32'h2004;
    issue(0, 0, 1, 0, 0, 0, 0, 32'h7000, 32'h7004, 4);
    n_tests++;
    if (tr_h[0] !== 1'b1 || tr_rsp[0] !== 3'b000 || tr_we[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_accept hold=%b rsp=%b we=%b, want 1 000 0", tr_h[0], tr_rsp[0], tr_we[0]);
    end
    n_tests++;
    if (tr_we[1] !== 1'b1 || tr_addr[1] !== 12'h300 || tr_wd[1] !== 32'h88 || tr_j[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_status we=%b addr=%h wd=%h j=%b, want 1 300 00000088 0",
               tr_we[1], tr_addr[1], tr_wd[1], tr_j[1]);
    end
    n_tests++;
    if (tr_j[2] !== 1'b1 || tr_jpc[2] !== 32'h2004 || tr_we[2] !== 1'b0 || tr_h[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_jump j=%b pc=%h we=%b hold=%b, want 1 00002004 0 1",
               tr_j[2], tr_jpc[2], tr_we[2], tr_h[2]);
    end
    n_tests++;
    if (tr_h[3] !== 1'b0 || tr_j[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_after hold=%b j=%b, want 0 0", tr_h[3], tr_j[3]);
    end
  endtask

  task automatic test_irq_order();
    logic [31:0] exp_tpc;
`ifdef TRAP_VECTOR_EN
    exp_tpc = 32'h11C;
`else
    exp_tpc = 32'h100;
`endif
    mstatus_v = 32'h8; mtvec_v = 32'h100;
    issue(0, 0, 0, 1, 1, 1, 1, 32'h800, 32'h804, 6);
    n_tests++;
    if (tr_rsp[0] !== 3'b100 || tr_wd[2] !== 32'h8000_000B) begin
      n_fail++;
      $display("FAIL order_ex rsp=%b mcause=%h, want 100 8000000b", tr_rsp[0], tr_wd[2]);
    end
    // handler returns with MIE=0 while soft/timer still pend
    mstatus_v = 32'h80; mepc_i = 32'h804;
    issue(0, 0, 1, 0, 1, 1, 0, 32'h180, 32'h184, 3);
    n_tests++;
    if (tr_rsp[0] !== 3'b000 || tr_j[2] !== 1'b1 || tr_jpc[2] !== 32'h804) begin
      n_fail++;
      $display("FAIL order_mret rsp=%b j=%b pc=%h, want 000 1 00000804", tr_rsp[0], tr_j[2], tr_jpc[2]);
    end
    mstatus_v = 32'h88;
    issue(0, 0, 0, 0, 1, 1, 1, 32'h804, 32'h808, 6);
    n_tests++;
    if (tr_rsp[0] !== 3'b010 || tr_wd[2] !== 32'h8000_0003 || tr_wd[1] !== 32'h808) begin
      n_fail++;
      $display("FAIL order_soft rsp=%b mcause=%h mepc=%h, want 010 80000003 808",
               tr_rsp[0], tr_wd[2], tr_wd[1]);
    end
    mstatus_v = 32'h88; mtvec_v = 32'h101;
    issue(0, 0, 0, 0, 0, 1, 1, 32'h900, 32'h904, 6);
    n_tests++;
    if (tr_rsp[0] !== 3'b001 || tr_wd[2] !== 32'h8000_0007 || tr_jpc[5] !== exp_tpc || tr_j[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL order_timer rsp=%b mcause=%h j=%b pc=%h, want 001 80000007 1 %h",
               tr_rsp[0], tr_wd[2], tr_j[5], tr_jpc[5], exp_tpc);
    end
    // exceptions use the base even in vectored mode
    issue(1, 0, 0, 0, 0, 0, 0, 32'hA00, 32'hA04, 6);
    n_tests++;
    if (tr_jpc[5] !== 32'h100 || tr_j[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_ecall j=%b pc=%h, want 1 00000100", tr_j[5], tr_jpc[5]);
    end
  endtask

  task automatic test_reset_mid();
    mstatus_v = 32'h8; mtvec_v = 32'h100;
    issue(0, 0, 0, 1, 0, 0, 1, 32'h2000, 32'h2004, 2);
    ex_trap_i = 1'b0;
    #1;
    n_tests++;
    if (trap_csr_we_o !== 1'b1 || trap_csr_addr_o !== 12'h342) begin
      n_fail++;
      $display("FAIL rstmid_in_mcause we=%b addr=%h, want 1 342", trap_csr_we_o, trap_csr_addr_o);
    end
    rst = 1'b1; #1;
    n_tests++;
    if (trap_csr_we_o !== 1'b0 || hold_o !== 1'b0 || jump_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_during we=%b hold=%b j=%b, want 0 0 0", trap_csr_we_o, hold_o, jump_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_tests++;
    if (trap_csr_we_o !== 1'b0 || hold_o !== 1'b0 || jump_o !== 1'b0 ||
        trap_csr_addr_o !== 12'h0 || trap_csr_wdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_after we=%b hold=%b j=%b addr=%h wd=%h, want 0 0 0 0 0",
               trap_csr_we_o, hold_o, jump_o, trap_csr_addr_o, trap_csr_wdata_o);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      n_tests++;
      if (jump_o !== 1'b0 || trap_csr_we_o !== 1'b0 || hold_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet%0d j=%b we=%b hold=%b, want 0 0 0", k, jump_o, trap_csr_we_o, hold_o);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ext_irq();
    test_ecall_no_mie();
    test_ebreak();
    test_ecall_beats_irq();
    test_no_accept();
    test_mret();
    test_irq_order();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
